// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 opcodes, FSM state encoding and counter sizing.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int XLEN_DEF = 32;
    localparam int CNT_W    = $clog2(XLEN_DEF);

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage (master) and the mul/div unit (slave).
// Valid/ready on both sides; flush and busy travel alongside.
interface muldiv_iter_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_src1;
    logic [XLEN-1:0] in_src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2, flush, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, flush, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply (i_mode=0) or restoring divide (i_mode=1).
// {i_hi,i_lo} is the product register or {partial remainder, dividend/quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_mode,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    always_comb begin
        w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
        w_rem_sh = {i_hi, i_lo[XLEN-1]};
        w_ge     = (w_rem_sh >= {1'b0, i_b});
        // Only taken when w_ge, so the result always fits XLEN bits.
        w_diff   = w_rem_sh[XLEN-1:0] - i_b;
        o_hi     = '0;
        o_lo     = '0;
        if (i_mode) begin
            o_hi = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], w_ge};
        end else begin
            o_hi = w_sum[XLEN:1];
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, one bit per cycle: result at T+XLEN+1, corner cases at T+1.
// Accepts only in IDLE; result held in DONE until out_ready; flush aborts at any point.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_iter_if.slave  bus
);
    localparam int CW = (XLEN == XLEN_DEF) ? CNT_W : cnt_width(XLEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_last;
    logic              w_sgn1;
    logic              w_sgn2;
    logic              w_s1;
    logic              w_s2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_qr;
    logic [XLEN-1:0]   w_qr_fix;
    logic [XLEN-1:0]   w_final;

    assign w_accept = bus.in_valid && (r_state == IDLE) && !bus.flush;
    assign w_last   = (r_cnt == CW'(XLEN - 1));

    always_comb begin
        w_sgn1 = 1'b0;
        w_sgn2 = 1'b0;
        case (bus.in_op)
            OP_MULH, OP_DIV, OP_REM: begin
                w_sgn1 = 1'b1;
                w_sgn2 = 1'b1;
            end
            OP_MULHSU: w_sgn1 = 1'b1;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: begin
                w_sgn1 = 1'b0;
                w_sgn2 = 1'b0;
            end
            default: ;
        endcase
        w_s1   = w_sgn1 && bus.in_src1[XLEN-1];
        w_s2   = w_sgn2 && bus.in_src2[XLEN-1];
        w_abs1 = w_s1 ? -bus.in_src1 : bus.in_src1;
        w_abs2 = w_s2 ? -bus.in_src2 : bus.in_src2;
    end

    // Corner cases resolved at accept: divide by zero and signed MIN / -1.
    always_comb begin
        w_div0 = bus.in_op[2] && (bus.in_src2 == '0);
        w_ovf  = ((bus.in_op == OP_DIV) || (bus.in_op == OP_REM)) &&
                 (bus.in_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_src2 == '1);
        w_special     = w_div0 || w_ovf;
        w_special_res = '0;
        if (w_div0)
            w_special_res = bus.in_op[1] ? bus.in_src1 : '1;
        else if (w_ovf)
            w_special_res = bus.in_op[1] ? '0 : bus.in_src1;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_mode (r_op[2]),
        .i_hi   (r_hi),
        .i_lo   (r_lo),
        .i_b    (r_b),
        .o_hi   (w_step_hi),
        .o_lo   (w_step_lo)
    );

    // Final iteration output is sign-fixed and selected in the same cycle it is produced.
    always_comb begin
        w_prod     = {w_step_hi, w_step_lo};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        w_qr       = r_op[1] ? w_step_hi : w_step_lo;
        w_qr_fix   = r_neg ? -w_qr : w_qr;
        w_final    = w_qr_fix;
        if (!r_op[2])
            w_final = (r_op == OP_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_special ? DONE : CALC;
            CALC: begin
                if (bus.flush)   w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            DONE: if (bus.flush || bus.out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op  <= bus.in_op;
                r_cnt <= '0;
                r_hi  <= '0;
                if (bus.in_op[2]) begin
                    r_lo  <= w_abs1;
                    r_b   <= w_abs2;
                    r_neg <= bus.in_op[1] ? w_s1 : (w_s1 ^ w_s2);
                end else begin
                    r_lo  <= w_abs2;
                    r_b   <= w_abs1;
                    r_neg <= w_s1 ^ w_s2;
                end
                if (w_special)
                    r_result <= w_special_res;
            end else if ((r_state == CALC) && !bus.flush) begin
                r_hi  <= w_step_hi;
                r_lo  <= w_step_lo;
                r_cnt <= r_cnt + 1'b1;
                if (w_last)
                    r_result <= w_final;
            end
        end
    end

    assign bus.in_ready   = (r_state == IDLE);
    assign bus.out_valid  = (r_state == DONE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.out_result = r_result;
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized and directed bench for muldiv_iter (XLEN=32) against an arithmetic reference model.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_S = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muldiv_iter_if #(.XLEN(XLEN)) bus ();

    muldiv_iter #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        int              ia;
        int              ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub;           return p[31:0];  end
            OP_MULH:   begin p = sa * sb;           return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;           return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_S && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN_S && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) ||
               ((op == OP_DIV || op == OP_REM) && a == MIN_S && b == 32'hFFFF_FFFF));
    endfunction

    // Called at #1 after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        int exp_lat;
        exp_lat = is_special(op, a, b) ? 0 : XLEN;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_src1  = $urandom;
        bus.in_src2  = $urandom;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " lat"}, n, exp_lat);
        check({tag, " res"}, bus.out_result, exp);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " idle"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        vec_t        vecs[12];
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] held;
        logic        seen;
        int          n;

        vecs[0]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{OP_MULH,   MIN_S,         MIN_S,         32'h4000_0000};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14};
        vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2};
        vecs[8]  = '{OP_DIV,    32'h55,        32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{OP_REMU,   32'h1234,      32'd0,         32'h1234};
        vecs[10] = '{OP_DIV,    MIN_S,         32'hFFFF_FFFF, MIN_S};
        vecs[11] = '{OP_REM,    MIN_S,         32'hFFFF_FFFF, 32'h0};

        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready",  32'(bus.in_ready),  1);
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst busy",      32'(bus.busy),      0);
        check("rst result",    bus.out_result,     0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = MIN_S; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, ref_op(op, a, b));
        end

        // Backpressure: result held while out_ready is low, new requests ignored.
        bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_src1 = 32'd7; bus.in_src2 = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("bp lat", n, XLEN);
        held = 32'hFFFF_FFEB;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = OP_DIVU;
            bus.in_src1  = $urandom;
            bus.in_src2  = 32'd3;
            check($sformatf("bp vld%0d", i), 32'(bus.out_valid), 1);
            check($sformatf("bp res%0d", i), bus.out_result, held);
            check($sformatf("bp rdy%0d", i), 32'(bus.in_ready), 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp idle rdy",  32'(bus.in_ready),  1);
        check("bp idle vld",  32'(bus.out_valid), 0);
        check("bp idle busy", 32'(bus.busy),      0);

        // Flush mid-calculation beats a simultaneous request.
        bus.in_valid = 1'b1; bus.in_op = OP_MULHU; bus.in_src1 = $urandom; bus.in_src2 = $urandom;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("fl busy pre", 32'(bus.busy), 1);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_op = OP_DIVU; bus.in_src1 = 32'd100; bus.in_src2 = 32'd7;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl busy",  32'(bus.busy),      0);
        check("fl vld",   32'(bus.out_valid), 0);
        check("fl rdy",   32'(bus.in_ready),  1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        check("fl no accept", 32'(seen), 0);

        // Flush in DONE together with out_ready.
        bus.in_valid = 1'b1; bus.in_op = OP_DIV; bus.in_src1 = 32'h77; bus.in_src2 = 32'h0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("fd vld",  32'(bus.out_valid), 1);
        check("fd res",  bus.out_result, 32'hFFFF_FFFF);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        check("fd idle vld", 32'(bus.out_valid), 0);
        check("fd idle rdy", 32'(bus.in_ready),  1);

        // Reset in the middle of an operation.
        bus.in_valid = 1'b1; bus.in_op = OP_DIVU; bus.in_src1 = 32'd1000; bus.in_src2 = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("mr busy",   32'(bus.busy),      0);
        check("mr vld",    32'(bus.out_valid), 0);
        check("mr rdy",    32'(bus.in_ready),  1);
        check("mr result", bus.out_result,     0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("post rst", OP_REM, 32'hFFFF_FF9C, 32'd7, ref_op(OP_REM, 32'hFFFF_FF9C, 32'd7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
